fir_engine: RTL
===============

Name: fir_engine

Overview:
Streaming multiply-accumulate datapath. It sits directly downstream of the FIR control FSM: it consumes ctrl_engine_t, returns flags_engine_t, takes three input streams (a, b, c) from the streamer sources and drives one output stream (d) into the streamer sink.
- Scalar-product mode: emits one result per group of len element pairs.
- simple_mul mode: emits one result per element.

Parameters:
DATA_WIDTH, 32, width of the a/b/c/d stream data (signed two's complement).
ACC_WIDTH, 64, accumulator and product width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ctrl_i  in  ctrl_engine_t  clear/enable/simple_mul/start/shift[4:0]/len[10:0]
flags_o  out  flags_engine_t  cnt[10:0], acc_valid
a_data_i  in  DATA_WIDTH  operand a
a_valid_i  in  1  a valid
a_ready_o  out  1  a ready
b_data_i  in  DATA_WIDTH  operand b
b_valid_i  in  1  b valid
b_ready_o  out  1  b ready
c_data_i  in  DATA_WIDTH  bias c
c_valid_i  in  1  c valid
c_ready_o  out  1  c ready
d_data_o  out  DATA_WIDTH  result
d_valid_o  out  1  result valid
d_ready_i  in  1  sink ready

Behaviour:
Interface timing:
- One clock domain: clk_i.
- rst_i is synchronous and active-high.
- ctrl_i.clear is a synchronous clear with the same effect as rst_i.
- Both rst_i and clear reset to zero: all pipeline valids, cnt, acc, acc_valid, d_data_o, d_valid_o, and the latched len/shift/simple_mul.

Configuration latch:
- ctrl_i.start (1-cycle pulse) latches len, shift and simple_mul, and zeroes cnt and acc.
- len==0 is latched as 1.
- No input is accepted in a start cycle.
- clear beats start.

Input join:
- need_c = simple_mul OR (cnt == len_q-1).
- fire = enable & ~start & ~stall & a_valid & b_valid & (c_valid | ~need_c).
- a_ready_o = b_ready_o = fire; c_ready_o = fire & need_c.
- Ready depends on valid; valid never depends on ready.

Pipeline (two register stages):
- Global stall = d_valid_o & ~d_ready_i. A stall freezes every stage, and d_data_o holds stable.
- S1 registers: prod = signed(a)*signed(b) as 64-bit; c; first flag (cnt==0); last flag (simple_mul | cnt==len_q-1).
- S2 accumulate: acc = first ? prod : acc+prod, wrapping mod 2^64.
- S2 output, when last:
  - d_data_o = truncate32(acc >>> shift) + c, mod 2^32.
  - d_valid_o asserts; in simple_mul mode acc = prod.
- Latency: an input fire on cycle t gives d_valid_o at t+2 (last element), absent stall.
- Throughput: 1 element/cycle.

Counter:
- cnt increments on fire and wraps to 0 after len_q elements.
- Groups continue back-to-back without a new start.
- flags_o.cnt is the registered count.

acc_valid:
- Mirrors d_valid_o in scalar-product mode.
- Stays 0 in simple_mul mode.

enable low:
- No new fire.
- Stages in flight still drain if not stalled.

Reset or clear mid-group:
- Partial sum is discarded.
- Any in-flight result is dropped, with no d_valid_o pulse afterwards.

Decomposition:
- fir_package holds ctrl_engine_t, flags_engine_t and FIR_CNT_LEN.
- Add FIR_DATA_WIDTH=32 and FIR_ACC_WIDTH=64 as package constants.
- One sub-module, fir_engine_mult: the registered signed multiplier stage with stall input, carrying the valid/first/last/c sideband. It allows later retiming into deeper multiplier pipelines.

Test Plan:
1. simple_mul=1, shift=0, a=3, b=-4, c=10 -> d=0xFFFFFFFE exactly 2 cycles after fire; acc_valid stays 0.
2. Scalar mode, len=4, shift=0:
   - Stimulus: a=1,2,3,4; b=5,6,7,8; c=100 with the 4th element.
   - Response: single d=170; acc_valid pulses once; cnt steps 1,2,3,0; c_ready_o only on the 4th element.
3. Shift rounding:
   - len=1, a=0x10000, b=0x100, c=0, shift=4 -> d=0x00100000.
   - a=-16, b=16, shift=4 -> d=0xFFFFFFF0 (arithmetic shift).
4. Backpressure: simple_mul with 8 elements, d_ready_i low for cycles 3-7 -> all 8 results in order, no loss or duplication, d_data_o stable while stalled, input readies low during the stall.
5. Mid-group clear: len=8, clear after 3 elements -> no output, cnt=0. Then start with len=2, a=2,3, b=4,5, c=0 -> d=23.
6. Edge cases:
   - start with len=0 -> behaves as len=1 (a=7, b=6, c=1 -> d=43).
   - start asserted together with valid inputs -> that element is not accepted.
   - clear and start asserted together -> clear wins.

Source files
------------

// File: rtl/fir_package.sv
// Shared types and constants for the FIR engine and its control FSM.
// Control and flag bundles are packed structs so they travel as single ports.
package fir_package;

    localparam int FIR_CNT_LEN    = 11;
    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_ACC_WIDTH  = 64;

    typedef struct packed {
        logic                   clear;
        logic                   enable;
        logic                   simple_mul;
        logic                   start;
        logic [4:0]             shift;
        logic [FIR_CNT_LEN-1:0] len;
    } ctrl_engine_t;

    typedef struct packed {
        logic [FIR_CNT_LEN-1:0] cnt;
        logic                   acc_valid;
    } flags_engine_t;

endpackage

// File: rtl/fir_engine_mult.sv
// Registered signed multiplier stage carrying valid/first/last/bias sideband.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: stall freezes every register; rst drops the in-flight element.
module fir_engine_mult #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        in_vld,
    input  logic [DATA_WIDTH-1:0]       a_dat,
    input  logic [DATA_WIDTH-1:0]       b_dat,
    input  logic [DATA_WIDTH-1:0]       c_dat,
    input  logic                        first,
    input  logic                        last,
    output logic                        out_vld,
    output logic signed [ACC_WIDTH-1:0] prod_dat,
    output logic [DATA_WIDTH-1:0]       out_c_dat,
    output logic                        out_first,
    output logic                        out_last
);

    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] b_ext;

    assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){a_dat[DATA_WIDTH-1]}}, a_dat};
    assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){b_dat[DATA_WIDTH-1]}}, b_dat};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            prod_dat  <= '0;
            out_c_dat <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_vld <= in_vld;
            if (in_vld) begin
                prod_dat  <= a_ext * b_ext;
                out_c_dat <= c_dat;
                out_first <= first;
                out_last  <= last;
            end
        end
    end

endmodule

// File: rtl/fir_engine.sv
// Streaming MAC: joins a/b/c, multiplies, accumulates groups of len and emits shifted sum plus bias.
// Latency: 2 cycles from the accepting cycle of a group's last element to d_valid_o.
// Backpressure: d_valid_o & ~d_ready_i freezes both stages and drops all input readies.
module fir_engine
    import fir_package::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ACC_WIDTH  = FIR_ACC_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ctrl_engine_t          ctrl_i,
    output flags_engine_t         flags_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] c_data_i,
    input  logic                  c_valid_i,
    output logic                  c_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  d_valid_o,
    input  logic                  d_ready_i
);

    logic                   flush;
    logic [FIR_CNT_LEN-1:0] len_q;
    logic [FIR_CNT_LEN-1:0] cnt_q;
    logic [4:0]             shift_q;
    logic                   simple_mul_q;
    logic                   acc_valid_q;
    logic                   cnt_last;
    logic                   need_c;
    logic                   stall;
    logic                   fire;

    logic                        s1_vld;
    logic signed [ACC_WIDTH-1:0] s1_prod;
    logic [DATA_WIDTH-1:0]       s1_c;
    logic                        s1_first;
    logic                        s1_last;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] acc_shift;
    logic [DATA_WIDTH-1:0]       d_next;

    // A clear cycle must not consume input, since everything it would feed is being wiped.
    assign flush    = rst_i | ctrl_i.clear;
    assign cnt_last = (cnt_q == len_q - FIR_CNT_LEN'(1));
    assign need_c   = simple_mul_q | cnt_last;
    assign stall    = d_valid_o & ~d_ready_i;
    assign fire     = ctrl_i.enable & ~ctrl_i.start & ~ctrl_i.clear & ~stall
                    & a_valid_i & b_valid_i & (c_valid_i | ~need_c);

    assign a_ready_o = fire;
    assign b_ready_o = fire;
    assign c_ready_o = fire & need_c;

    assign flags_o.cnt       = cnt_q;
    assign flags_o.acc_valid = acc_valid_q;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            len_q        <= '0;
            shift_q      <= '0;
            simple_mul_q <= 1'b0;
            cnt_q        <= '0;
        end else if (ctrl_i.start) begin
            len_q        <= (ctrl_i.len == '0) ? FIR_CNT_LEN'(1) : ctrl_i.len;
            shift_q      <= ctrl_i.shift;
            simple_mul_q <= ctrl_i.simple_mul;
            cnt_q        <= '0;
        end else if (fire) begin
            cnt_q <= cnt_last ? '0 : cnt_q + FIR_CNT_LEN'(1);
        end
    end

    fir_engine_mult #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mult (
        .clk       (clk_i),
        .rst       (flush),
        .stall     (stall),
        .in_vld    (fire),
        .a_dat     (a_data_i),
        .b_dat     (b_data_i),
        .c_dat     (c_data_i),
        .first     (simple_mul_q | (cnt_q == '0)),
        .last      (need_c),
        .out_vld   (s1_vld),
        .prod_dat  (s1_prod),
        .out_c_dat (s1_c),
        .out_first (s1_first),
        .out_last  (s1_last)
    );

    assign acc_sum   = s1_first ? s1_prod : acc_q + s1_prod;
    assign acc_shift = acc_sum >>> shift_q;
    assign d_next    = acc_shift[DATA_WIDTH-1:0] + s1_c;

    // Start only zeroes acc; an element retiring in the same cycle overrides it via its first flag.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            acc_q       <= '0;
            d_data_o    <= '0;
            d_valid_o   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            if (ctrl_i.start) begin
                acc_q <= '0;
            end
            if (!stall) begin
                d_valid_o   <= s1_vld & s1_last;
                acc_valid_q <= s1_vld & s1_last & ~simple_mul_q;
                if (s1_vld) begin
                    acc_q <= acc_sum;
                    if (s1_last) begin
                        d_data_o <= d_next;
                    end
                end
            end
        end
    end

endmodule
